param_simple_cpu: RTL and testbench
===================================

# param_simple_cpu

Parametrised successor to the four-opcode accumulator CPU. It uses a unified instruction/data memory, configurable address width, a 3-bit opcode space adding LDA/STA/JZ/HLT, a carry flag, a halt state and a memory preload port. It is a standalone top-level block with a multi-cycle FSM datapath of PC, AR, DR, IR and AC. Architectural state is exposed on observation ports for the bench.

## Interface
- `ADDR_W`, default 6: address width. Memory depth is 2^ADDR_W words.
- `WORD_W`, derived, equal to ADDR_W+3 (default 9). Not overridable. Sets the width of memory words, AC and DR.
- `clk` in, 1: single clock. All state changes on the rising edge.
- `resetn` in, 1: asynchronous, active-low reset.
- `ld_we` in, 1: preload write enable.
- `ld_addr` in, ADDR_W: preload address.
- `ld_data` in, WORD_W: preload data.
- `pc_o` out, ADDR_W: program counter.
- `ac_o` out, WORD_W: accumulator.
- `carry_o` out, 1: carry flag.
- `halted_o` out, 1: high while in the HALT state.
- `instr_done_o` out, 1: one-cycle pulse in the cycle after an instruction's last execute state.

## Operation
- **Instruction word:** `[WORD_W-1:ADDR_W]` is the opcode, `[ADDR_W-1:0]` is the address field.
- **Opcodes:**
  - 000 ADD: AC←AC+M[a], carry←carry-out.
  - 001 AND: AC←AC&M[a], carry unchanged.
  - 010 JMP: PC←a.
  - 011 INC: AC←AC+1, carry←carry-out, address field ignored.
  - 100 LDA: AC←M[a].
  - 101 STA: M[a]←AC.
  - 110 JZ: PC←a if AC==0, else no effect.
  - 111 HLT: enter HALT.
- **Memory:** 2^ADDR_W × WORD_W array named `mem`.
  - Combinational read at AR; synchronous write.
  - Reset does not clear memory.
  - The bench may preload `mem` hierarchically or through the ld port.
- **Preload port:** when `ld_we`=1, M[ld_addr]←ld_data at the clock edge, in any state.
- **Write collision:** if `ld_we` and an STA write occur in the same cycle, the preload write wins and the STA write is dropped, even for different addresses.
- **FSM states and transitions:**
  - FETCH1: AR←PC. Stays in FETCH1 while `ld_we`=1 (stall); otherwise goes to FETCH2.
  - FETCH2: DR←M[AR], PC←PC+1 mod 2^ADDR_W. Goes to FETCH3.
  - FETCH3: IR←DR opcode, AR←DR address field. Goes to the execute state for the opcode.
  - ADD1/AND1/LDA1: DR←M[AR]. Go to ADD2/AND2/LDA2.
  - ADD2/AND2/LDA2: AC update. Go to FETCH1.
  - INC1, JMP1, JZ1, STA1: single execute cycle each. Go to FETCH1.
  - HLT1 goes to HALT.
  - HALT is absorbing: no PC, AC, carry or memory changes from the CPU. The preload port still writes. Only reset leaves HALT.
- **Arithmetic:**
  - Additions are WORD_W+1 bits wide. The MSB goes to carry; AC takes the low WORD_W bits (wraps).
  - PC increment wraps from 2^ADDR_W−1 to 0 and does not affect carry.
  - JZ tests the full WORD_W-bit AC.

## Timing
- **Reset values** (while `resetn`=0 and immediately after assertion): state FETCH1, PC/AR/IR/DR/AC=0, `carry_o`=0, `halted_o`=0, `instr_done_o`=0.
- **Reset mid-instruction:** asserting `resetn` low in any state aborts immediately. No partial writeback; an STA1 in progress does not write.
- **First fetch:** begins on the first rising edge with `resetn`=1 and `ld_we`=0.
- **Instruction length** (from FETCH1 entry to the next FETCH1): ADD/AND/LDA 5 cycles; INC/JMP/JZ/STA 4 cycles; HLT 4 cycles to HALT.
- **`instr_done_o`:** high in the first FETCH1 cycle after any instruction other than HLT completes. Never asserted for HLT.
- **HLT indication:** `halted_o` rises in the cycle HALT is entered.
- **Output registers:** `pc_o`, `ac_o` and `carry_o` are the architectural registers, updated at the edge ending the corresponding state.
- **STA timing:** the memory write is visible to a combinational read on the next cycle.

## Test plan
- **ADD/INC:** M[0]=INC, M[1]=ADD 32, M[2]=HLT, M[32]=5 → after 1st `instr_done_o` AC=1; after 2nd AC=6, carry=0; `halted_o`=1 at cycle 13 after reset release, PC=3.
- **Overflow and JZ:** M[0]=LDA 33, M[1]=INC, M[2]=JZ 10, M[10]=HLT, M[33]=9'h1FF → after INC AC=0, carry=1; JZ taken, PC=10; halts with PC=11. Repeat with M[33]=9'h0FE → AC=0FF, carry=0, JZ not taken, PC=3.
- **STA/LDA round trip and collision:**
  - M[0]=LDA 40, M[1]=STA 41, M[2]=AND 42, M[3]=LDA 41, M[4]=HLT, M[40]=9'h0B6, M[42]=9'h00F → M[41]=0B6, AC=0B6 after LDA, AND result=006 observed before the reload.
  - Assert `ld_we` to address 50 during STA1 → M[41] unchanged, M[50] written.
- **PC wrap and preload stall:** preload via ld port M[0]=JMP 63, M[63]=INC, holding `ld_we` for 3 cycles after reset release → PC stays 0 during the stall; after INC executes, PC=0 (wrap), AC=1.
- **Reset mid-operation:** pulse `resetn` low for 3 ns during ADD2 with AC=4 → AC=0, PC=0, `carry_o`=0 immediately (asynchronous); fetch restarts at M[0].
- **HALT persistence:** after HLT, run 50 cycles → PC, AC and carry unchanged, `instr_done_o` never pulses, `halted_o` stays 1; release by reset only.

Source files
------------

// File: rtl/param_simple_cpu_if.sv
// Preload and observation bundle for param_simple_cpu.
// The bench owns the preload port; the CPU publishes its architectural state.
`timescale 1ns/1ps
interface param_simple_cpu_if #(
  parameter int ADDR_W = 6
);
  localparam int WORD_W = ADDR_W + 3;

  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [WORD_W-1:0] ld_data;
  logic [ADDR_W-1:0] pc_o;
  logic [WORD_W-1:0] ac_o;
  logic              carry_o;
  logic              halted_o;
  logic              instr_done_o;

  modport master (
    output ld_we, ld_addr, ld_data,
    input  pc_o, ac_o, carry_o, halted_o, instr_done_o
  );

  modport slave (
    input  ld_we, ld_addr, ld_data,
    output pc_o, ac_o, carry_o, halted_o, instr_done_o
  );
endinterface

// File: rtl/param_simple_cpu.sv
// Multi-cycle accumulator CPU with unified memory, 3-bit opcodes, carry flag,
// absorbing HALT state and a preload port that has priority over STA writes.
`timescale 1ns/1ps
module param_simple_cpu #(
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                resetn,
  param_simple_cpu_if.slave   cpu_bus
);
  localparam int WORD_W = ADDR_W + 3;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_JMP = 3'b010;
  localparam logic [2:0] OP_INC = 3'b011;
  localparam logic [2:0] OP_LDA = 3'b100;
  localparam logic [2:0] OP_STA = 3'b101;
  localparam logic [2:0] OP_JZ  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH1, S_FETCH2, S_FETCH3,
    S_ADD1, S_ADD2, S_AND1, S_AND2, S_LDA1, S_LDA2,
    S_INC1, S_JMP1, S_JZ1, S_STA1, S_HLT1, S_HALT
  } state_t;

  logic [WORD_W-1:0] mem [DEPTH];

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_ar;
  logic [2:0]        r_ir;
  logic [WORD_W-1:0] r_dr;
  logic [WORD_W-1:0] r_ac;
  logic              r_carry;
  logic              r_halted;
  logic              r_done;
  logic              w_done_next;
  logic              w_sta_we;
  logic [WORD_W-1:0] w_mem_rd;
  logic [WORD_W:0]   w_alu;

  // {carry, AC} result for the accumulator-writing opcodes; others keep both.
  function automatic logic [WORD_W:0] alu_f(
    input logic [2:0]        op,
    input logic [WORD_W-1:0] ac,
    input logic [WORD_W-1:0] dr,
    input logic              carry
  );
    case (op)
      OP_ADD:  alu_f = {1'b0, ac} + {1'b0, dr};
      OP_INC:  alu_f = {1'b0, ac} + {{WORD_W{1'b0}}, 1'b1};
      OP_AND:  alu_f = {carry, ac & dr};
      OP_LDA:  alu_f = {carry, dr};
      default: alu_f = {carry, ac};
    endcase
  endfunction

  assign w_mem_rd = mem[r_ar];
  assign w_alu    = alu_f(r_ir, r_ac, r_dr, r_carry);
  assign w_sta_we = (r_state == S_STA1);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_FETCH1;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; dispatch uses the opcode still held in DR at FETCH3.
  always_comb begin
    w_next      = r_state;
    w_done_next = 1'b0;
    case (r_state)
      S_FETCH1: begin
        if (cpu_bus.ld_we) begin
          w_next = S_FETCH1;
        end else begin
          w_next = S_FETCH2;
        end
      end
      S_FETCH2: w_next = S_FETCH3;
      S_FETCH3: begin
        case (r_dr[WORD_W-1:ADDR_W])
          OP_ADD:  w_next = S_ADD1;
          OP_AND:  w_next = S_AND1;
          OP_JMP:  w_next = S_JMP1;
          OP_INC:  w_next = S_INC1;
          OP_LDA:  w_next = S_LDA1;
          OP_STA:  w_next = S_STA1;
          OP_JZ:   w_next = S_JZ1;
          OP_HLT:  w_next = S_HLT1;
          default: w_next = S_HLT1;
        endcase
      end
      S_ADD1: w_next = S_ADD2;
      S_AND1: w_next = S_AND2;
      S_LDA1: w_next = S_LDA2;
      S_ADD2, S_AND2, S_LDA2, S_INC1, S_JMP1, S_JZ1, S_STA1: begin
        w_next      = S_FETCH1;
        w_done_next = 1'b1;
      end
      S_HLT1:  w_next = S_HALT;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH1;
    endcase
  end

  // Datapath registers: PC, AR, IR, DR, AC and carry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc    <= {ADDR_W{1'b0}};
      r_ar    <= {ADDR_W{1'b0}};
      r_ir    <= 3'b000;
      r_dr    <= {WORD_W{1'b0}};
      r_ac    <= {WORD_W{1'b0}};
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH1: r_ar <= r_pc;
        S_FETCH2: begin
          r_dr <= w_mem_rd;
          r_pc <= r_pc + ADDR_W'(1);
        end
        S_FETCH3: begin
          r_ir <= r_dr[WORD_W-1:ADDR_W];
          r_ar <= r_dr[ADDR_W-1:0];
        end
        S_ADD1, S_AND1, S_LDA1: r_dr <= w_mem_rd;
        S_ADD2, S_AND2, S_LDA2, S_INC1: {r_carry, r_ac} <= w_alu;
        S_JMP1: r_pc <= r_ar;
        S_JZ1: begin
          if (r_ac == {WORD_W{1'b0}}) begin
            r_pc <= r_ar;
          end
        end
        default: r_pc <= r_pc;
      endcase
    end
  end

  // Status flags, registered from the next-state decode.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_halted <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_halted <= (w_next == S_HALT);
      r_done   <= w_done_next;
    end
  end

  // Memory write port: preload always wins a same-cycle STA.
  always_ff @(posedge clk) begin
    if (cpu_bus.ld_we) begin
      mem[cpu_bus.ld_addr] <= cpu_bus.ld_data;
    end else if (w_sta_we) begin
      mem[r_ar] <= r_ac;
    end
  end

  assign cpu_bus.pc_o         = r_pc;
  assign cpu_bus.ac_o         = r_ac;
  assign cpu_bus.carry_o      = r_carry;
  assign cpu_bus.halted_o     = r_halted;
  assign cpu_bus.instr_done_o = r_done;
endmodule

// File: tb/tb_param_simple_cpu.sv
// Bench for param_simple_cpu: instruction-level reference model checked every
// cycle, plus directed programs with hand-computed expectations.
`timescale 1ns/1ps
module tb_param_simple_cpu;
  localparam int AW = 6;
  localparam int WW = 9;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_JMP = 3'b010;
  localparam logic [2:0] OP_INC = 3'b011;
  localparam logic [2:0] OP_LDA = 3'b100;
  localparam logic [2:0] OP_STA = 3'b101;
  localparam logic [2:0] OP_JZ  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  param_simple_cpu_if #(.ADDR_W(AW)) bus ();
  param_simple_cpu #(.ADDR_W(AW)) dut (.clk(clk), .resetn(resetn), .cpu_bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural state plus a cycle position in the instruction
  logic [WW-1:0] mm [64];
  logic [AW-1:0] m_pc   = '0;
  logic [WW-1:0] m_ac   = '0;
  logic          m_c    = 1'b0;
  logic          m_halt = 1'b0;
  logic          m_done = 1'b0;
  int            m_phase = 0;
  int            m_len   = 4;
  int            m_sum;
  logic [2:0]    m_op;
  logic [AW-1:0] m_a;

  logic [15:0] q_pc[$];
  logic [15:0] q_ac[$];
  logic [15:0] q_c[$];
  logic [AW-1:0] pa[$];
  logic [WW-1:0] pd[$];

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      m_pc = '0; m_ac = '0; m_c = 1'b0; m_halt = 1'b0; m_done = 1'b0; m_phase = 0;
    end else begin
      m_done = 1'b0;
      if (!m_halt) begin
        if (m_phase == 0) begin
          if (!bus.ld_we) m_phase = 1;
        end else if (m_phase == 1) begin
          m_op  = mm[m_pc][WW-1:AW];
          m_a   = mm[m_pc][AW-1:0];
          m_len = (m_op inside {OP_ADD, OP_AND, OP_LDA}) ? 5 : 4;
          m_pc  = m_pc + 1'b1;
          m_phase = 2;
        end else if (m_phase < m_len - 1) begin
          m_phase++;
        end else begin
          case (m_op)
            OP_ADD: begin m_sum = int'(m_ac) + int'(mm[m_a]); m_c = (m_sum > 511); m_ac = WW'(m_sum % 512); end
            OP_INC: begin m_sum = int'(m_ac) + 1;             m_c = (m_sum > 511); m_ac = WW'(m_sum % 512); end
            OP_AND: m_ac = m_ac & mm[m_a];
            OP_LDA: m_ac = mm[m_a];
            OP_JMP: m_pc = m_a;
            OP_JZ:  if (m_ac == 0) m_pc = m_a;
            OP_STA: if (!bus.ld_we) mm[m_a] = m_ac;
            default: m_halt = 1'b1;
          endcase
          m_done  = (m_op != OP_HLT);
          m_phase = 0;
        end
      end
      if (bus.ld_we) mm[bus.ld_addr] = bus.ld_data;
    end
  end

  // Per-cycle comparison against the model, and a log of instr_done samples
  initial forever begin
    @(negedge clk);
    n_tests++;
    if (bus.pc_o !== m_pc || bus.ac_o !== m_ac || bus.carry_o !== m_c ||
        bus.halted_o !== m_halt || bus.instr_done_o !== m_done) begin
      n_fail++;
      $display("FAIL model t=%0t: got pc=%0h ac=%0h c=%0b h=%0b d=%0b, expected pc=%0h ac=%0h c=%0b h=%0b d=%0b",
               $time, bus.pc_o, bus.ac_o, bus.carry_o, bus.halted_o, bus.instr_done_o,
               m_pc, m_ac, m_c, m_halt, m_done);
    end
    if (bus.instr_done_o === 1'b1) begin
      q_pc.push_back(16'(bus.pc_o));
      q_ac.push_back(16'(bus.ac_o));
      q_c.push_back(16'(bus.carry_o));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic ld(input int a, input int d);
    pa.push_back(AW'(a));
    pd.push_back(WW'(d));
  endtask

  // Reset, then preload through the port while the CPU stalls in FETCH1.
  // Returns at the negedge of cycle 0 with ld_we low.
  task automatic start_prog();
    @(negedge clk);
    resetn = 1'b0;
    bus.ld_we = 1'b0;
    q_pc.delete(); q_ac.delete(); q_c.delete();
    repeat (2) @(negedge clk);
    chk("reset_pc", 16'(bus.pc_o), 16'h0);
    chk("reset_ac", 16'(bus.ac_o), 16'h0);
    chk("reset_flags", {13'b0, bus.carry_o, bus.halted_o, bus.instr_done_o}, 16'h0);
    resetn = 1'b1;
    for (int i = 0; i < pa.size(); i++) begin
      if (i > 0) begin
        @(negedge clk);
        chk("stall_pc", 16'(bus.pc_o), 16'h0);
      end
      bus.ld_we = 1'b1; bus.ld_addr = pa[i]; bus.ld_data = pd[i];
    end
    @(negedge clk);
    bus.ld_we = 1'b0;
    pa.delete(); pd.delete();
  endtask

  task automatic run_halt(input int budget);
    int i = 0;
    while (bus.halted_o !== 1'b1 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("halt_reached", 16'(bus.halted_o), 16'h1);
  endtask

  initial begin
    bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    #1 resetn = 1'b0;

    // ADD/INC with exact cycle timing
    for (int a = 0; a < 64; a++) ld(a, 0);
    ld(0, 9'h0C0); ld(1, 9'h020); ld(2, 9'h1C0); ld(32, 9'h005);
    start_prog();
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 4) begin chk("t1_done1", 16'(bus.instr_done_o), 16'h1); chk("t1_ac1", 16'(bus.ac_o), 16'h001); end
      if (c == 9) begin
        chk("t1_done2", 16'(bus.instr_done_o), 16'h1);
        chk("t1_ac2", 16'(bus.ac_o), 16'h006);
        chk("t1_c2", 16'(bus.carry_o), 16'h0);
      end
      if (c == 12) chk("t1_not_yet_halted", 16'(bus.halted_o), 16'h0);
      if (c == 13) begin chk("t1_halted", 16'(bus.halted_o), 16'h1); chk("t1_pc", 16'(bus.pc_o), 16'h3); end
    end

    // Overflow, JZ taken
    ld(0, 9'h121); ld(1, 9'h0C0); ld(2, 9'h18A); ld(3, 9'h1C0); ld(10, 9'h1C0); ld(33, 9'h1FF);
    start_prog();
    run_halt(40);
    chk("t2a_ndone", 16'(q_ac.size()), 16'd3);
    if (q_ac.size() == 3) begin
      chk("t2a_lda_ac", q_ac[0], 16'h1FF);
      chk("t2a_inc_ac", q_ac[1], 16'h000);
      chk("t2a_inc_c",  q_c[1],  16'h1);
      chk("t2a_jz_pc",  q_pc[2], 16'd10);
    end
    chk("t2a_final_pc", 16'(bus.pc_o), 16'd11);

    // JZ not taken
    ld(33, 9'h0FE);
    start_prog();
    run_halt(40);
    chk("t2b_ndone", 16'(q_ac.size()), 16'd3);
    if (q_ac.size() == 3) begin
      chk("t2b_inc_ac", q_ac[1], 16'h0FF);
      chk("t2b_inc_c",  q_c[1],  16'h0);
      chk("t2b_jz_pc",  q_pc[2], 16'd3);
    end
    chk("t2b_final_pc", 16'(bus.pc_o), 16'd4);

    // STA/LDA round trip
    ld(0, 9'h128); ld(1, 9'h169); ld(2, 9'h06A); ld(3, 9'h129); ld(4, 9'h1C0);
    ld(40, 9'h0B6); ld(42, 9'h00F);
    start_prog();
    run_halt(60);
    chk("t3_ndone", 16'(q_ac.size()), 16'd4);
    if (q_ac.size() == 4) begin
      chk("t3_lda_ac", q_ac[0], 16'h0B6);
      chk("t3_and_ac", q_ac[2], 16'h006);
      chk("t3_reload_ac", q_ac[3], 16'h0B6);
    end
    chk("t3_mem41", 16'(dut.mem[41]), 16'h0B6);

    // Same program, preload to 50 collides with STA1 (cycle 8)
    ld(41, 9'h055);
    start_prog();
    repeat (8) @(negedge clk);
    chk("t3c_pc_at_sta1", 16'(bus.pc_o), 16'd2);
    bus.ld_we = 1'b1; bus.ld_addr = 6'd50; bus.ld_data = 9'h123;
    @(negedge clk);
    bus.ld_we = 1'b0;
    run_halt(60);
    chk("t3c_mem41", 16'(dut.mem[41]), 16'h055);
    chk("t3c_mem50", 16'(dut.mem[50]), 16'h123);
    chk("t3c_ac", 16'(bus.ac_o), 16'h055);

    // PC wrap after a 3-cycle preload stall
    ld(0, 9'h0BF); ld(63, 9'h0C0); ld(1, 9'h1C0);
    start_prog();
    repeat (8) @(negedge clk);
    chk("t4_done", 16'(bus.instr_done_o), 16'h1);
    chk("t4_pc_wrap", 16'(bus.pc_o), 16'h0);
    chk("t4_ac", 16'(bus.ac_o), 16'h001);
    if (q_pc.size() == 2) chk("t4_jmp_pc", q_pc[0], 16'd63);
    else chk("t4_ndone", 16'(q_pc.size()), 16'd2);

    // Asynchronous reset during ADD2 (cycle 9)
    ld(0, 9'h120); ld(1, 9'h021); ld(2, 9'h1C0); ld(32, 9'h004); ld(33, 9'h003);
    start_prog();
    repeat (9) @(negedge clk);
    chk("t5_ac_before", 16'(bus.ac_o), 16'h004);
    #1 resetn = 1'b0;
    #1;
    chk("t5_async_pc", 16'(bus.pc_o), 16'h0);
    chk("t5_async_ac", 16'(bus.ac_o), 16'h0);
    chk("t5_async_c", 16'(bus.carry_o), 16'h0);
    #2 resetn = 1'b1;
    q_pc.delete(); q_ac.delete(); q_c.delete();
    run_halt(40);
    if (q_ac.size() == 2) begin
      chk("t5_restart_pc", q_pc[0], 16'd1);
      chk("t5_restart_ac", q_ac[0], 16'h004);
    end else chk("t5_ndone", 16'(q_ac.size()), 16'd2);
    chk("t5_final_ac", 16'(bus.ac_o), 16'h007);
    chk("t5_final_pc", 16'(bus.pc_o), 16'd3);

    // HALT persistence; preload still writes while halted
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      bus.ld_we = (c == 20);
      bus.ld_addr = 6'd20; bus.ld_data = 9'h1AB;
      chk("t6_halt_state", {bus.instr_done_o, bus.halted_o, bus.carry_o, bus.pc_o, bus.ac_o[6:0]},
          {1'b0, 1'b1, 1'b0, 6'd3, 7'h07});
      chk("t6_ac_hi", 16'(bus.ac_o[8:7]), 16'h0);
    end
    chk("t6_preload", 16'(dut.mem[20]), 16'h1AB);
    @(negedge clk);
    resetn = 1'b0;
    #1 chk("t6_reset_leaves_halt", 16'(bus.halted_o), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
